// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mem_pkg;

  // Access size, i_mem_op[1:0]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Exception codes reported with o_done
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_LD_ALIGN = 2'b01;
  localparam logic [1:0] EXC_ST_ALIGN = 2'b10;
  localparam logic [1:0] EXC_BAD_SIZE = 2'b11;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_REQ   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  // Reserved size wins over alignment; bytes can never be misaligned.
  function automatic logic [1:0] access_exc(input logic       is_store,
                                            input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic misaligned;
    misaligned = 1'b0;
    if (size == SZ_HALF) misaligned = addr_lo[0];
    if (size == SZ_WORD) misaligned = (addr_lo != 2'b00);
    if (size == SZ_RSVD)  return EXC_BAD_SIZE;
    else if (misaligned)  return is_store ? EXC_ST_ALIGN : EXC_LD_ALIGN;
    else                  return EXC_NONE;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] rd_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Little-endian: the addressed lane is moved down to bit 0.
  assign rd_shift = i_rd_word >> {i_addr_lo, 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  // Size-dependent lane enables, replicated write data and extended load data
  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = i_wr_data;
    o_ld_data = i_rd_word;
    case (i_size)
      SZ_BYTE: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wr_data[7:0]}};
        o_ld_data = {{24{~i_unsigned & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        o_be      = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata   = {2{i_wr_data[15:0]}};
        o_ld_data = {{16{~i_unsigned & ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        o_be = 4'b1111;
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check plus one req/ack data-memory access.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_REQ   | o_mem_req held high until i_mem_ack
// ST_DONE  | o_done pulse, no exception
// ST_FAULT | o_done pulse with exception, no memory access made
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_mem_op,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_eff_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [1:0]        o_exception,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        exc_q, exc_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]  la_size;
  logic [1:0]  la_addr_lo;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_ld_data;
  logic [1:0]  start_exc;

  // The lane logic serves the incoming request in IDLE (enables, store
  // data) and the latched request in REQ (load extraction), never both.
  assign la_size    = (state_q == ST_IDLE) ? i_mem_op[1:0]   : op_q[1:0];
  assign la_addr_lo = (state_q == ST_IDLE) ? i_eff_addr[1:0] : addr_lo_q;
  assign start_exc  = access_exc(i_mem_op[2], i_mem_op[1:0], i_eff_addr[1:0]);

  mem_lane_align u_lane (
    .i_size     (la_size),
    .i_addr_lo  (la_addr_lo),
    .i_unsigned (uns_q),
    .i_wr_data  (i_wr_data),
    .i_rd_word  (i_mem_rdata),
    .o_be       (la_be),
    .o_wdata    (la_wdata),
    .o_ld_data  (la_ld_data)
  );

  // Next-state and next-output logic; every output comes straight from a flop
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    uns_d     = uns_q;
    addr_lo_d = addr_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;
    exc_d     = exc_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d      = i_mem_op;
          uns_d     = i_unsigned;
          addr_lo_d = i_eff_addr[1:0];
          busy_d    = 1'b1;
          if (start_exc != EXC_NONE) begin
            state_d = ST_FAULT;
            done_d  = 1'b1;
            exc_d   = start_exc;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = i_mem_op[2];
            maddr_d = {i_eff_addr[ADDR_W-1:2], 2'b00};
            be_d    = la_be;
            wdata_d = la_wdata;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          exc_d   = EXC_NONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          maddr_d = '0;
          be_d    = 4'b0000;
          wdata_d = '0;
          if (!op_q[2]) rd_data_d = la_ld_data;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'b000;
      uns_q     <= 1'b0;
      addr_lo_q <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      exc_q     <= EXC_NONE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      uns_q     <= uns_d;
      addr_lo_q <= addr_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      exc_q     <= exc_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rd_data   = rd_data_q;
  assign o_exception = exc_q;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random and directed accesses,
// a memory responder checking the bus side, a monitor checking completions.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_mem_op = 3'b000;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_eff_addr = 32'h0;
  logic [31:0] i_wr_data = 32'h0;
  logic        o_busy, o_done, o_mem_req, o_mem_we;
  logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_exception;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'h0;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_mem_op    (i_mem_op),
    .i_unsigned  (i_unsigned),
    .i_eff_addr  (i_eff_addr),
    .i_wr_data   (i_wr_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_data   (o_rd_data),
    .o_exception (o_exception),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  exc;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
  } mem_exp_t;

  done_exp_t   done_q[$];
  mem_exp_t    mem_q[$];
  int          total = 0;
  int          passed = 0;
  logic [31:0] last_rd = 32'h0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endfunction

  // Reference model: bytes touched are [off, off+n) of the word.
  function automatic void model(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                                input logic [31:0] wr, input logic [31:0] rdata,
                                output logic [1:0] exc, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int n, off;
    n   = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : (op[1:0] == 2'd3) ? 4 : 0;
    off = int'(addr[1:0]);
    exc = 2'd0;
    if (n == 0) exc = 2'd3;
    else if ((off % n) != 0) exc = op[2] ? 2'd2 : 2'd1;
    be = 4'h0;
    wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) be[i] = 1'b1;
      if (n > 0) wd[8*i +: 8] = wr[8*(i % n) +: 8];
    end
    ld = rdata >> (8 * off);
    if (n == 1) begin
      ld = ld & 32'hFF;
      if (!uns && ld[7]) ld = ld | 32'hFFFF_FF00;
    end else if (n == 2) begin
      ld = ld & 32'hFFFF;
      if (!uns && ld[15]) ld = ld | 32'hFFFF_0000;
    end else begin
      ld = rdata;
    end
  endfunction

  // Memory responder: checks the request against the scoreboard, acks after wt extra cycles
  initial begin : responder
    mem_exp_t e;
    bit       aborted;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_mem_req) begin
        check("req_expected", 32'(mem_q.size() > 0), 32'd1);
        if (mem_q.size() == 0) begin
          for (int k = 0; k < 50 && o_mem_req; k++) @(negedge i_clk);
        end else begin
          e = mem_q.pop_front();
          check("mem_addr", o_mem_addr, e.addr);
          check("mem_be", 32'(o_mem_be), 32'(e.be));
          check("mem_we", 32'(o_mem_we), 32'(e.we));
          if (e.we) check("mem_wdata", o_mem_wdata, e.wdata);
          aborted = 1'b0;
          for (int k = 0; k < e.wt; k++) begin
            @(negedge i_clk);
            if (!o_mem_req) begin
              aborted = 1'b1;
              break;
            end
          end
          if (!aborted) begin
            check("mem_addr_hold", o_mem_addr, e.addr);
            check("mem_be_hold", 32'(o_mem_be), 32'(e.be));
            i_mem_ack   = 1'b1;
            i_mem_rdata = e.rdata;
            @(posedge i_clk);
            #1;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'($urandom);
            @(negedge i_clk);
            check("req_drop", 32'(o_mem_req), 32'd0);
          end
        end
      end
    end
  end

  // Completion monitor
  always @(negedge i_clk) begin
    if (i_rst_n && o_done) begin
      if (done_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: o_done=1 with exception %0d, none outstanding", o_exception);
      end else begin
        done_exp_t d;
        d = done_q.pop_front();
        check("rd_data", o_rd_data, d.rd);
        check("exception", 32'(o_exception), 32'(d.exc));
      end
    end
  end

  // Called just after a rising edge with the unit idle.
  task automatic do_access(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                           input logic [31:0] wr, input logic [31:0] rdata, input int wt,
                           input bit poke);
    logic [1:0]  exc;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    int          cnt, lat;
    bit          got;
    model(op, uns, addr, wr, rdata, exc, be, wd, ld);
    if (exc == 2'd0) mem_q.push_back('{addr & 32'hFFFF_FFFC, be, op[2], wd, rdata, wt});
    if (exc == 2'd0 && !op[2]) last_rd = ld;
    done_q.push_back('{last_rd, exc});
    lat = (exc != 2'd0) ? 1 : 2 + wt;
    i_mem_op   = op;
    i_unsigned = uns;
    i_eff_addr = addr;
    i_wr_data  = wr;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_eff_addr = 32'($urandom);
    i_wr_data  = 32'($urandom);
    i_mem_op   = 3'($urandom_range(0, 7));
    i_unsigned = 1'($urandom_range(0, 1));
    cnt = 0;
    got = 1'b0;
    while (cnt < 60 && !got) begin
      @(negedge i_clk);
      cnt++;
      if (cnt == 1) check("busy_after_start", 32'(o_busy), 32'd1);
      if (poke && cnt == 1) i_start = 1'b1;
      if (poke && cnt == 2) i_start = 1'b0;
      if (o_done) got = 1'b1;
    end
    i_start = 1'b0;
    check("done_latency", got ? 32'(cnt) : 32'd999, 32'(lat));
    @(posedge i_clk);
    #1;
    check("busy_back_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    check("rst_exception", 32'(o_exception), 32'd0);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_mem_we", 32'(o_mem_we), 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_be", 32'(o_mem_be), 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed cases from the plan
    do_access(3'b000, 1'b0, 32'h1003, 32'h0, 32'h80FF_0102, 2, 1'b0);
    check("lb_signed_value", o_rd_data, 32'hFFFF_FF80);
    do_access(3'b001, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 1'b0);
    check("lhu_value", o_rd_data, 32'h0000_8001);
    do_access(3'b100, 1'b0, 32'h0000_0011, 32'hAABB_CCDD, 32'h0, 1, 1'b0);
    check("sb_keeps_rd", o_rd_data, 32'h0000_8001);
    do_access(3'b111, 1'b0, 32'h0000_0006, 32'h1234_5678, 32'h0, 0, 1'b0);
    do_access(3'b001, 1'b0, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b0);
    do_access(3'b010, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 0, 1'b0);

    // Second start during REQ must be dropped, then a spurious ack in IDLE
    do_access(3'b011, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
    i_mem_ack = 1'b1;
    repeat (2) begin
      @(negedge i_clk);
      check("spurious_ack_busy", 32'(o_busy), 32'd0);
      check("spurious_ack_req", 32'(o_mem_req), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_mem_ack = 1'b0;

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      do_access(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 32'($urandom),
                32'($urandom), 32'($urandom), $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of a request
    mem_q.push_back('{32'h0000_0200, 4'hF, 1'b0, 32'h0, 32'h0, 1000});
    i_mem_op   = 3'b011;
    i_eff_addr = 32'h0000_0200;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(negedge i_clk);
    check("rst_test_req_up", 32'(o_mem_req), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(o_mem_req), 32'd0);
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_done", 32'(o_done), 32'd0);
    check("async_rst_rd", o_rd_data, 32'd0);
    last_rd = 32'h0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_mem_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_mem_ack = 1'b0;
    check("late_ack_ignored", 32'(o_busy), 32'd0);

    do_access(3'b011, 1'b0, 32'h0000_0100, 32'h0, 32'h5A5A_0F0F, 1, 1'b0);
    check("lw_after_reset", o_rd_data, 32'h5A5A_0F0F);

    repeat (4) @(posedge i_clk);
    check("done_queue_drained", 32'(done_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit of the MEM stage. It takes the effective address produced by the address generation unit, checks alignment, and drives one byte-lane-masked access to data memory over a req/ack handshake. It returns sign- or zero-extended load data, or an exception code, with a single-cycle completion pulse. It is the consumer side of the effective-address interface.

## Interface
- `DATA_W`, default 32: data width; only 32 is supported.
- `ADDR_W`, default 32: effective address width.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  request strobe; sampled only in IDLE.
- `i_mem_op`  in  3  `[2]` 1 = store, 0 = load; `[1:0]` size: 00 byte, 01 half, 11 word, 10 reserved.
- `i_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `i_eff_addr`  in  ADDR_W  effective (byte) address.
- `i_wr_data`  in  DATA_W  store data, right-justified.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rd_data`  out  DATA_W  extended load data; valid while `o_done` is high, held until the next completion.
- `o_exception`  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 reserved size; valid with `o_done`.
- `o_mem_req`  out  1  memory request; held until ack.
- `o_mem_we`  out  1  write enable.
- `o_mem_addr`  out  ADDR_W  word address; `[1:0]` is always 00.
- `o_mem_be`  out  4  byte enables.
- `o_mem_wdata`  out  DATA_W  lane-replicated write data.
- `i_mem_ack`  in  1  memory completion.
- `i_mem_rdata`  in  DATA_W  read word; valid in the ack cycle.

## Operation
- **Reset values:** state IDLE. All outputs are 0: `o_busy`, `o_done`, `o_rd_data`, `o_exception`, and all `o_mem_*`.
- **States:** IDLE, REQ, DONE, FAULT.
- **IDLE, `i_start` = 1:**
  - The unit latches op, unsigned, address and data.
  - If the access is misaligned or the size is reserved, it moves to FAULT.
  - Otherwise it moves to REQ.
- **IDLE, `i_start` = 0:** the unit stays in IDLE. `i_mem_ack` is ignored in IDLE.
- **Misalignment rules:** half is misaligned if `addr[0]`; word is misaligned if `addr[1:0]` != 00; byte is never misaligned. The reserved size has priority over the misalignment check.
- **REQ:**
  - `o_mem_req` = 1. `o_mem_addr` = `{addr[31:2], 2'b00}`. `o_mem_we` = store.
  - The unit stays in REQ until `i_mem_ack`. On ack it moves to DONE; for a load it captures the extracted data.
- **DONE:** `o_done` = 1 with `o_exception` = 00, then IDLE.
- **FAULT:** `o_done` = 1 with the exception code, then IDLE. No memory request is issued.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1], 1'b0}`
  - word: `4'b1111`
- **Write data:**
  - byte: `{4{wr[7:0]}}`
  - half: `{2{wr[15:0]}}`
  - word: `wr`
- **Load extraction (little-endian):**
  - byte: `rdata >> (8*addr[1:0])`, taking bits `[7:0]`.
  - half: `rdata >> (16*addr[1])`, taking bits `[15:0]`.
  - Both are then sign- or zero-extended per `i_unsigned`. `i_unsigned` is ignored for word loads and for stores.
- **`o_rd_data` on stores and faults:** unchanged.
- **Inputs while busy:** `i_start` while `o_busy` is dropped, with no queueing. Input changes after the IDLE sample have no effect.

## Timing
- All outputs are registered.
- **Accepted access:**
  - `i_start` is sampled at edge 0.
  - `o_mem_req` rises after edge 0.
  - An ack sampled at edge k (k >= 1) gives `o_done` high for the cycle after edge k.
  - With zero-wait memory (ack in the first REQ cycle), `o_done` occurs 2 cycles after `i_start`.
  - Back-to-back throughput is one access per 3 cycles.
- **Faulted access:** `o_done` is high for the cycle after edge 0, i.e. latency 1 cycle.
- `o_mem_req` drops in the cycle after the ack edge. `o_mem_addr`, `o_mem_be`, `o_mem_we` and `o_mem_wdata` are stable for the whole REQ interval.
- `o_busy` is high from the cycle after `i_start` through the `o_done` cycle. A new `i_start` is accepted in the first cycle after `o_done`.
- **Reset mid-operation:** `i_rst_n` low forces IDLE and clears all outputs immediately (asynchronously), including `o_mem_req`. The in-flight request is abandoned and a late ack is ignored.

## Structure
- Shared package `mem_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - exception codes `EXC_NONE`, `EXC_LD_ALIGN`, `EXC_ST_ALIGN`, `EXC_BAD_SIZE`
  - the state encoding
- One combinational sub-module, `mem_lane_align`, computes byte enables, write-data replication and load extraction/extension. The FSM and latches stay in `mem_access_unit`.

## Test plan
- **Signed byte load.** Inputs: LB, addr 0x1003, memory returns 0x80FF_0102 with ack after 3 cycles. Required: `o_mem_addr` 0x1000, `o_mem_be` 0001 << 3 = 1000, `o_rd_data` 0xFFFF_FF80, exception 00, `o_done` one cycle after the ack edge.
- **Unsigned half load.** Inputs: LHU, addr 0x2002, memory returns 0x8001_1234 with zero wait. Required: be 1100, `o_rd_data` 0x0000_8001, `o_done` 2 cycles after start.
- **Byte store.** Inputs: SB, addr 0x11, data 0xAABB_CCDD. Required: `o_mem_we` = 1, be 0010, wdata 0xDDDD_DDDD, `o_mem_addr` 0x10.
- **Misaligned word store.** Inputs: SW, addr 0x06. Required: no `o_mem_req` ever asserted, `o_done` 1 cycle later with exception 10. Repeat as LH at 0x05: exception 01. Repeat with size 10: exception 11.
- **Start while busy / late ack.** Inputs: second `i_start` during REQ, then a spurious `i_mem_ack` in IDLE. Required: only one request and one `o_done`, no state change from the spurious ack.
- **Reset mid-request.** Inputs: assert `i_rst_n` = 0 while in REQ. Required: `o_mem_req`, `o_busy` and `o_done` go low without waiting for a clock edge; after release the unit is in IDLE and a subsequent LW at 0x100 completes normally.
